trd_status_ctrl: RTL

TRD_STATUS_CTRL -- requirements
Module: trd_status_ctrl

---
 rtl/trd_status_ctrl_if.sv | 42 ++++
 rtl/trd_status_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/trd_status_ctrl_if.sv
// rtl/trd_status_ctrl_if.sv - thread event, readback and status bundle for trd_status_ctrl
interface trd_status_ctrl_if #(
    parameter int NUM_TRD = 8,
    parameter int TID_W   = 3
);
    logic               spawn_vld;
    logic [TID_W-1:0]   spawn_trd;
    logic               done_vld;
    logic [TID_W-1:0]   done_trd;
    logic               alu_exp;
    logic [TID_W-1:0]   alu_trd;
    logic               inv_op;
    logic [TID_W-1:0]   inv_op_trd;
    logic               seg_fault;
    logic [TID_W-1:0]   seg_trd;
    logic               breakpoint;
    logic [TID_W-1:0]   bp_trd;
    logic               clr_vld;
    logic [TID_W-1:0]   clr_trd;
    logic [TID_W-1:0]   rd_trd;
    logic [7:0]         rd_status;
    logic [7:0]         rd_cnt;
    logic [NUM_TRD-1:0] trd_run;
    logic [NUM_TRD-1:0] trd_excp;
    logic               excp_irq;
    logic               spawn_err;
    logic               all_idle;

    modport master (
        output spawn_vld, spawn_trd, done_vld, done_trd, alu_exp, alu_trd,
               inv_op, inv_op_trd, seg_fault, seg_trd, breakpoint, bp_trd,
               clr_vld, clr_trd, rd_trd,
        input  rd_status, rd_cnt, trd_run, trd_excp, excp_irq, spawn_err, all_idle
    );

    modport slave (
        input  spawn_vld, spawn_trd, done_vld, done_trd, alu_exp, alu_trd,
               inv_op, inv_op_trd, seg_fault, seg_trd, breakpoint, bp_trd,
               clr_vld, clr_trd, rd_trd,
        output rd_status, rd_cnt, trd_run, trd_excp, excp_irq, spawn_err, all_idle
    );
endinterface

// File: rtl/trd_status_ctrl.sv
// rtl/trd_status_ctrl.sv - per-thread IDLE/RUN/EXCP tracker with cause latch and status readback
// Optional per-thread saturating exception counters enabled by TRD_EXCP_CNT_EN.
module trd_status_ctrl #(
    parameter int NUM_TRD = 8,
    parameter int TID_W   = 3
) (
    input  logic           clk,
    input  logic           rst,
    trd_status_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_EXCP = 2'd2;

    logic [1:0]         r_state     [NUM_TRD];
    logic [3:0]         r_cause     [NUM_TRD];
    logic [1:0]         w_state_nxt [NUM_TRD];
    logic [3:0]         w_cause_nxt [NUM_TRD];
    logic [NUM_TRD-1:0] w_enter_excp;
    logic [NUM_TRD-1:0] w_spawn_bad;
    logic [NUM_TRD-1:0] w_trd_run;
    logic [NUM_TRD-1:0] w_trd_excp;
    logic [1:0]         w_rd_state;
    logic               r_excp_irq;
    logic               r_spawn_err;

    // The unused encoding 3 is treated as IDLE everywhere it is observed.
    function automatic logic [1:0] st_dec(input logic [1:0] s);
        return (s == 2'd3) ? ST_IDLE : s;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TRD; i++) begin
                r_state[i] <= ST_IDLE;
                r_cause[i] <= 4'd0;
            end
            r_excp_irq  <= 1'b0;
            r_spawn_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_TRD; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cause[i] <= w_cause_nxt[i];
            end
            r_excp_irq  <= |w_enter_excp;
            r_spawn_err <= |w_spawn_bad;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_TRD; i++) begin
            logic w_spawn, w_done, w_alu, w_inv, w_seg, w_bp, w_clr;
            w_spawn = bus.spawn_vld  && (bus.spawn_trd  == TID_W'(i));
            w_done  = bus.done_vld   && (bus.done_trd   == TID_W'(i));
            w_alu   = bus.alu_exp    && (bus.alu_trd    == TID_W'(i));
            w_inv   = bus.inv_op     && (bus.inv_op_trd == TID_W'(i));
            w_seg   = bus.seg_fault  && (bus.seg_trd    == TID_W'(i));
            w_bp    = bus.breakpoint && (bus.bp_trd     == TID_W'(i));
            w_clr   = bus.clr_vld    && (bus.clr_trd    == TID_W'(i));
            w_state_nxt[i]  = st_dec(r_state[i]);
            w_cause_nxt[i]  = r_cause[i];
            w_enter_excp[i] = 1'b0;
            w_spawn_bad[i]  = 1'b0;
            case (st_dec(r_state[i]))
                ST_IDLE: begin
                    if (w_spawn) w_state_nxt[i] = ST_RUN;
                end
                ST_RUN: begin
                    w_spawn_bad[i] = w_spawn;
                    // An exception beats a same-cycle done.
                    if (w_seg || w_inv || w_alu || w_bp) begin
                        w_state_nxt[i]  = ST_EXCP;
                        w_enter_excp[i] = 1'b1;
                        if (w_seg)      w_cause_nxt[i] = 4'd3;
                        else if (w_inv) w_cause_nxt[i] = 4'd2;
                        else if (w_alu) w_cause_nxt[i] = 4'd1;
                        else            w_cause_nxt[i] = 4'd4;
                    end else if (w_done) begin
                        w_state_nxt[i] = ST_IDLE;
                    end
                end
                ST_EXCP: begin
                    w_spawn_bad[i] = w_spawn;
                    if (w_clr) begin
                        w_state_nxt[i] = ST_IDLE;
                        w_cause_nxt[i] = 4'd0;
                    end
                end
                default: w_state_nxt[i] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_TRD; i++) begin
            w_trd_run[i]  = (st_dec(r_state[i]) == ST_RUN);
            w_trd_excp[i] = (st_dec(r_state[i]) == ST_EXCP);
        end
        w_rd_state = st_dec(r_state[bus.rd_trd]);
    end

    assign bus.trd_run   = w_trd_run;
    assign bus.trd_excp  = w_trd_excp;
    assign bus.all_idle  = ~|(w_trd_run | w_trd_excp);
    assign bus.rd_status = {2'b00, w_rd_state, r_cause[bus.rd_trd]};
    assign bus.excp_irq  = r_excp_irq;
    assign bus.spawn_err = r_spawn_err;

`ifdef TRD_EXCP_CNT_EN
    logic [7:0] r_cnt [NUM_TRD];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TRD; i++) r_cnt[i] <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_TRD; i++) begin
                if (w_enter_excp[i] && (r_cnt[i] != 8'hFF)) r_cnt[i] <= r_cnt[i] + 8'd1;
            end
        end
    end

    assign bus.rd_cnt = r_cnt[bus.rd_trd];
`else
    assign bus.rd_cnt = 8'd0;
`endif
endmodule
